// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - bitwise logic unit behind a LATENCY-stage valid/ready pipeline
// Define LOGIC_UNIT_FLAGS_EN to add res_zero/res_parity carried alongside reg_d.
module logic_unit_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] reg_s1,
   input  logic [WIDTH-1:0] reg_s2,
   input  logic [2:0]       op,
   input  logic             enable,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] reg_d,
`ifdef LOGIC_UNIT_FLAGS_EN
   output logic             res_zero,
   output logic             res_parity,
`endif
   output logic [CNT_W-1:0] res_cnt
);

   logic [LATENCY-1:0] v;
   logic [WIDTH-1:0]   d [LATENCY];
   logic [LATENCY-1:0] rdy;
   logic [WIDTH-1:0]   result;
   logic [CNT_W-1:0]   cnt;

   always_comb begin
      result = '0;
      if (enable) begin
         case (op)
            3'd0:    result = reg_s1 & reg_s2;
            3'd1:    result = reg_s1 | reg_s2;
            3'd2:    result = reg_s1 ^ reg_s2;
            3'd3:    result = ~(reg_s1 ^ reg_s2);
            3'd4:    result = ~(reg_s1 & reg_s2);
            3'd5:    result = ~(reg_s1 | reg_s2);
            3'd6:    result = reg_s1 & ~reg_s2;
            default: result = reg_s1;
         endcase
      end
   end

   // Stage k can load when any stage from k to the output has room or the output drains.
   always_comb begin
      logic acc;
      acc = out_ready;
      rdy = '0;
      for (int k = LATENCY - 1; k >= 0; k--) begin
         acc    = acc | ~v[k];
         rdy[k] = acc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v   <= '0;
         cnt <= '0;
         for (int k = 0; k < LATENCY; k++) d[k] <= '0;
      end else begin
         if (rdy[0]) begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= result;
         end
         for (int k = 1; k < LATENCY; k++) begin
            if (rdy[k]) begin
               v[k] <= v[k-1];
               if (v[k-1]) d[k] <= d[k-1];
            end
         end
         if (v[LATENCY-1] & out_ready) cnt <= cnt + 1'b1;
      end
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   logic [LATENCY-1:0] z;
   logic [LATENCY-1:0] p;

   always_ff @(posedge clk) begin
      if (reset) begin
         z <= '0;
         p <= '0;
      end else begin
         if (rdy[0] & in_valid) begin
            z[0] <= (result == '0);
            p[0] <= ^result;
         end
         for (int k = 1; k < LATENCY; k++) begin
            if (rdy[k] & v[k-1]) begin
               z[k] <= z[k-1];
               p[k] <= p[k-1];
            end
         end
      end
   end

   assign res_zero   = v[LATENCY-1] & z[LATENCY-1];
   assign res_parity = v[LATENCY-1] & p[LATENCY-1];
`endif

   assign in_ready  = rdy[0];
   assign out_valid = v[LATENCY-1];
   assign reg_d     = d[LATENCY-1];
   assign res_cnt   = cnt;

endmodule
